// File: rtl/acl_cfg_pkg.sv
// Shared types and constants for the ADXL362 threshold/timer preset sequencer.
package acl_cfg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_GAP,
        ST_DONE
    } t_cfgseq_state;

    localparam logic [7:0] ADDR_THRESH_ACT_L   = 8'h20;
    localparam logic [7:0] ADDR_THRESH_ACT_H   = 8'h21;
    localparam logic [7:0] ADDR_TIME_ACT       = 8'h22;
    localparam logic [7:0] ADDR_THRESH_INACT_L = 8'h23;
    localparam logic [7:0] ADDR_THRESH_INACT_H = 8'h24;
    localparam logic [7:0] ADDR_TIME_INACT_L   = 8'h25;
    localparam logic [7:0] ADDR_TIME_INACT_H   = 8'h26;
    localparam logic [7:0] ADDR_POWER_CTL      = 8'h2D;

    localparam logic [3:0]  c_cfg_last_step = 4'd8;
    localparam logic [10:0] c_thresh_max    = 11'd2047;

endpackage

// File: rtl/cfg_step_rom.sv
// Maps a sequence step index and preset values to the ADXL362 register write,
// applying the 11-bit threshold and 8-bit activity-time saturation.
module cfg_step_rom
    import acl_cfg_pkg::*;
#(
    parameter logic [7:0] parm_power_ctl_measure = 8'h02,
    parameter logic [7:0] parm_power_ctl_standby = 8'h00
) (
    input  logic [3:0]  i_step,
    input  logic [15:0] i_thresh,
    input  logic [15:0] i_timer,
    output logic [7:0]  o_addr,
    output logic [7:0]  o_data
);

    logic [10:0] thr_sat;
    logic [7:0]  tact_sat;

    assign thr_sat  = (i_thresh > 16'd2047) ? c_thresh_max : i_thresh[10:0];
    assign tact_sat = (i_timer > 16'd255) ? 8'hFF : i_timer[7:0];

    always_comb begin
        o_addr = 8'h00;
        o_data = 8'h00;
        case (i_step)
            4'd0: begin o_addr = ADDR_POWER_CTL;      o_data = parm_power_ctl_standby;  end
            4'd1: begin o_addr = ADDR_THRESH_ACT_L;   o_data = thr_sat[7:0];            end
            4'd2: begin o_addr = ADDR_THRESH_ACT_H;   o_data = {5'b0, thr_sat[10:8]};   end
            4'd3: begin o_addr = ADDR_TIME_ACT;       o_data = tact_sat;                end
            4'd4: begin o_addr = ADDR_THRESH_INACT_L; o_data = thr_sat[7:0];            end
            4'd5: begin o_addr = ADDR_THRESH_INACT_H; o_data = {5'b0, thr_sat[10:8]};   end
            4'd6: begin o_addr = ADDR_TIME_INACT_L;   o_data = i_timer[7:0];            end
            4'd7: begin o_addr = ADDR_TIME_INACT_H;   o_data = i_timer[15:8];           end
            4'd8: begin o_addr = ADDR_POWER_CTL;      o_data = parm_power_ctl_measure;  end
            default: begin o_addr = 8'h00;            o_data = 8'h00;                   end
        endcase
    end

endmodule

// File: rtl/thresh_preset_cfg_sequencer.sv
// Writes the active threshold/timer preset to the ADXL362 as a nine-step
// req/ack register sequence. Define THRESH_CFG_ACK_TIMEOUT_EN for ack timeout.
module thresh_preset_cfg_sequencer
    import acl_cfg_pkg::*;
#(
    parameter logic [7:0]  parm_power_ctl_measure = 8'h02,
    parameter logic [7:0]  parm_power_ctl_standby = 8'h00,
    parameter logic [15:0] parm_ack_timeout       = 16'd50000
) (
    input  logic        i_clk_20mhz,
    input  logic        i_rstn_20mhz,
    input  logic        i_enable,
    input  logic [3:0]  i_preset_enum,
    input  logic [15:0] i_preset_thresh,
    input  logic [15:0] i_preset_timer,
    output logic        o_wr_req,
    output logic [7:0]  o_wr_addr,
    output logic [7:0]  o_wr_data,
    input  logic        i_wr_ack,
    output logic        o_cfg_busy,
    output logic        o_cfg_done,
    output logic [3:0]  o_cfg_enum,
    output logic        o_cfg_error
);

    t_cfgseq_state state_q, state_d;
    logic [3:0]  step_q, step_d;
    logic [3:0]  enum_lat_q, enum_lat_d;
    logic [15:0] thresh_lat_q, thresh_lat_d;
    logic [15:0] timer_lat_q, timer_lat_d;
    logic        wr_req_q, wr_req_d;
    logic [7:0]  wr_addr_q, wr_addr_d;
    logic [7:0]  wr_data_q, wr_data_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [3:0]  cfg_enum_q, cfg_enum_d;
    logic        valid_q, valid_d;
`ifdef THRESH_CFG_ACK_TIMEOUT_EN
    logic [15:0] ack_cnt_q, ack_cnt_d;
    logic        error_q, error_d;
`endif

    // The ROM only matters when loading a new write: step 0 from live inputs
    // on trigger, otherwise the step after the current one from latched values.
    logic [3:0]  rom_step;
    logic [15:0] rom_thresh, rom_timer;
    logic [7:0]  rom_addr, rom_data;
    logic        trigger;

    assign rom_step   = (state_q == ST_IDLE) ? 4'd0 : step_q + 4'd1;
    assign rom_thresh = (state_q == ST_IDLE) ? i_preset_thresh : thresh_lat_q;
    assign rom_timer  = (state_q == ST_IDLE) ? i_preset_timer : timer_lat_q;
    assign trigger    = i_enable && (!valid_q || (i_preset_enum != cfg_enum_q));

    cfg_step_rom #(
        .parm_power_ctl_measure(parm_power_ctl_measure),
        .parm_power_ctl_standby(parm_power_ctl_standby)
    ) u_step_rom (
        .i_step  (rom_step),
        .i_thresh(rom_thresh),
        .i_timer (rom_timer),
        .o_addr  (rom_addr),
        .o_data  (rom_data)
    );

    always_comb begin
        state_d      = state_q;
        step_d       = step_q;
        enum_lat_d   = enum_lat_q;
        thresh_lat_d = thresh_lat_q;
        timer_lat_d  = timer_lat_q;
        wr_req_d     = wr_req_q;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        cfg_enum_d   = cfg_enum_q;
        valid_d      = valid_q;
`ifdef THRESH_CFG_ACK_TIMEOUT_EN
        ack_cnt_d    = ack_cnt_q;
        error_d      = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (trigger) begin
                    enum_lat_d   = i_preset_enum;
                    thresh_lat_d = i_preset_thresh;
                    timer_lat_d  = i_preset_timer;
                    step_d       = 4'd0;
                    wr_req_d     = 1'b1;
                    busy_d       = 1'b1;
                    wr_addr_d    = rom_addr;
                    wr_data_d    = rom_data;
                    state_d      = ST_WAIT;
`ifdef THRESH_CFG_ACK_TIMEOUT_EN
                    ack_cnt_d    = 16'd0;
`endif
                end
            end
            ST_WAIT: begin
                if (i_wr_ack) begin
                    wr_req_d = 1'b0;
                    if (step_q == c_cfg_last_step) begin
                        done_d     = 1'b1;
                        busy_d     = 1'b0;
                        cfg_enum_d = enum_lat_q;
                        valid_d    = 1'b1;
                        state_d    = ST_DONE;
                    end else begin
                        step_d    = step_q + 4'd1;
                        wr_addr_d = rom_addr;
                        wr_data_d = rom_data;
                        state_d   = ST_GAP;
                    end
                end
`ifdef THRESH_CFG_ACK_TIMEOUT_EN
                else if (ack_cnt_q == parm_ack_timeout - 16'd1) begin
                    wr_req_d = 1'b0;
                    busy_d   = 1'b0;
                    error_d  = 1'b1;
                    state_d  = ST_IDLE;
                end else begin
                    ack_cnt_d = ack_cnt_q + 16'd1;
                end
`endif
            end
            ST_GAP: begin
                wr_req_d = 1'b1;
                state_d  = ST_WAIT;
`ifdef THRESH_CFG_ACK_TIMEOUT_EN
                ack_cnt_d = 16'd0;
`endif
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk_20mhz or negedge i_rstn_20mhz) begin
        if (!i_rstn_20mhz) begin
            state_q      <= ST_IDLE;
            step_q       <= 4'd0;
            enum_lat_q   <= 4'h0;
            thresh_lat_q <= 16'h0000;
            timer_lat_q  <= 16'h0000;
            wr_req_q     <= 1'b0;
            wr_addr_q    <= 8'h00;
            wr_data_q    <= 8'h00;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            cfg_enum_q   <= 4'h0;
            valid_q      <= 1'b0;
`ifdef THRESH_CFG_ACK_TIMEOUT_EN
            ack_cnt_q    <= 16'd0;
            error_q      <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            step_q       <= step_d;
            enum_lat_q   <= enum_lat_d;
            thresh_lat_q <= thresh_lat_d;
            timer_lat_q  <= timer_lat_d;
            wr_req_q     <= wr_req_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            cfg_enum_q   <= cfg_enum_d;
            valid_q      <= valid_d;
`ifdef THRESH_CFG_ACK_TIMEOUT_EN
            ack_cnt_q    <= ack_cnt_d;
            error_q      <= error_d;
`endif
        end
    end

    assign o_wr_req   = wr_req_q;
    assign o_wr_addr  = wr_addr_q;
    assign o_wr_data  = wr_data_q;
    assign o_cfg_busy = busy_q;
    assign o_cfg_done = done_q;
    assign o_cfg_enum = cfg_enum_q;
`ifdef THRESH_CFG_ACK_TIMEOUT_EN
    assign o_cfg_error = error_q;
`else
    assign o_cfg_error = 1'b0;
`endif

endmodule

// File: tb/tb_thresh_preset_cfg_sequencer.sv
// Self-checking bench for thresh_preset_cfg_sequencer; define
// THRESH_CFG_ACK_TIMEOUT_EN to also exercise the ack timeout.
module tb_thresh_preset_cfg_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic [3:0]  p_enum;
    logic [15:0] p_thresh;
    logic [15:0] p_timer;
    logic        wr_req;
    logic [7:0]  wr_addr;
    logic [7:0]  wr_data;
    logic        wr_ack;
    logic        cfg_busy;
    logic        cfg_done;
    logic [3:0]  cfg_enum;
    logic        cfg_error;

    int checks = 0;
    int errors = 0;
    logic [3:0] applied_enum;

    always #25 clk = ~clk;

    thresh_preset_cfg_sequencer #(.parm_ack_timeout(16'd20)) dut (
        .i_clk_20mhz    (clk),
        .i_rstn_20mhz   (rst_n),
        .i_enable       (enable),
        .i_preset_enum  (p_enum),
        .i_preset_thresh(p_thresh),
        .i_preset_timer (p_timer),
        .o_wr_req       (wr_req),
        .o_wr_addr      (wr_addr),
        .o_wr_data      (wr_data),
        .i_wr_ack       (wr_ack),
        .o_cfg_busy     (cfg_busy),
        .o_cfg_done     (cfg_done),
        .o_cfg_enum     (cfg_enum),
        .o_cfg_error    (cfg_error)
    );

    // Reference: expected {addr,data} of write w, from plain arithmetic on the preset.
    function automatic logic [15:0] exp_write(input int w, input logic [15:0] th, input logic [15:0] tm);
        int thr;
        int tact;
        int a;
        int d;
        thr  = (int'(th) > 2047) ? 2047 : int'(th);
        tact = (int'(tm) > 255) ? 255 : int'(tm);
        a = 0;
        d = 0;
        case (w)
            0: begin a = 'h2D; d = 'h00;             end
            1: begin a = 'h20; d = thr % 256;        end
            2: begin a = 'h21; d = thr / 256;        end
            3: begin a = 'h22; d = tact;             end
            4: begin a = 'h23; d = thr % 256;        end
            5: begin a = 'h24; d = thr / 256;        end
            6: begin a = 'h25; d = int'(tm) % 256;   end
            7: begin a = 'h26; d = int'(tm) / 256;   end
            default: begin a = 'h2D; d = 'h02;       end
        endcase
        return {8'(a), 8'(d)};
    endfunction

    // Acts as the SPI driver for one sequence and checks every write against
    // the reference. Optionally changes inputs after write chg_step is acked,
    // or asserts reset while write rst_step is pending.
    task automatic run_seq(input logic [3:0] e, input logic [15:0] th, input logic [15:0] tm,
                           input int chg_step, input logic [3:0] ne, input logic [15:0] nth,
                           input logic [15:0] ntm, input logic nen, input int rst_step);
        int waited;
        int hold;
        logic [15:0] exp;
        for (int w = 0; w < 9; w++) begin
            exp = exp_write(w, th, tm);
            waited = 0;
            do begin
                @(negedge clk);
                waited++;
            end while (wr_req !== 1'b1 && waited < 200);
            checks++;
            if (waited !== 1) begin
                errors++;
                $display("[TB] FAIL req_latency w=%0d got %0d cycles want 1", w, waited);
            end
            checks++;
            if ({wr_addr, wr_data} !== exp) begin
                errors++;
                $display("[TB] FAIL write w=%0d got %h/%h want %h/%h", w, wr_addr, wr_data, exp[15:8], exp[7:0]);
            end
            checks++;
            if (cfg_busy !== 1'b1) begin
                errors++;
                $display("[TB] FAIL busy w=%0d got %b want 1", w, cfg_busy);
            end
            if (w == rst_step) begin
                rst_n = 1'b0;
                #1;
                checks++;
                if (wr_req !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL async_reset_req got %b want 0", wr_req);
                end
                applied_enum = 4'h0;
                return;
            end
            hold = $urandom_range(0, 4);
            for (int h = 0; h < hold; h++) begin
                @(negedge clk);
                checks++;
                if (wr_req !== 1'b1 || {wr_addr, wr_data} !== exp) begin
                    errors++;
                    $display("[TB] FAIL hold w=%0d got req=%b %h/%h want req=1 %h/%h",
                             w, wr_req, wr_addr, wr_data, exp[15:8], exp[7:0]);
                end
            end
            wr_ack = 1'b1;
            @(negedge clk);
            wr_ack = 1'b0;
            if (w == chg_step) begin
                p_enum   = ne;
                p_thresh = nth;
                p_timer  = ntm;
                enable   = nen;
            end
            if (w < 8) begin
                checks++;
                if (wr_req !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL gap w=%0d got req=%b want 0", w, wr_req);
                end
            end else begin
                applied_enum = e;
                checks++;
                if (cfg_done !== 1'b1 || cfg_enum !== e || cfg_busy !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL done got done=%b enum=%h busy=%b want done=1 enum=%h busy=0",
                             cfg_done, cfg_enum, cfg_busy, e);
                end
                @(negedge clk);
                checks++;
                if (cfg_done !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL done_pulse got %b want 0", cfg_done);
                end
            end
        end
    endtask

    task automatic expect_quiet(input int cycles, input string name);
        int seen;
        seen = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (wr_req !== 1'b0) seen++;
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("[TB] FAIL %s got %0d req cycles want 0", name, seen);
        end
    endtask

    task automatic set_preset(input logic [3:0] e, input logic [15:0] th, input logic [15:0] tm);
        p_enum   = e;
        p_thresh = th;
        p_timer  = tm;
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        enable   = 1'b0;
        wr_ack   = 1'b0;
        set_preset(4'h0, 16'd150, 16'd10);
        applied_enum = 4'h0;
        repeat (3) @(negedge clk);
        checks++;
        if ({wr_req, wr_addr, wr_data, cfg_busy, cfg_done, cfg_enum, cfg_error} !== 23'd0) begin
            errors++;
            $display("[TB] FAIL reset_values got req=%b addr=%h data=%h busy=%b done=%b enum=%h err=%b want all 0",
                     wr_req, wr_addr, wr_data, cfg_busy, cfg_done, cfg_enum, cfg_error);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_enable_gate();
        expect_quiet(100, "enable_gate");
        enable = 1'b1;
        run_seq(4'h0, 16'd150, 16'd10, -1, 4'h0, 16'd0, 16'd0, 1'b1, -1);
    endtask

    task automatic test_saturation();
        set_preset(4'h5, 16'd3000, 16'd700);
        run_seq(4'h5, 16'd3000, 16'd700, -1, 4'h0, 16'd0, 16'd0, 1'b1, -1);
    endtask

    task automatic test_boundaries();
        logic [15:0] th_tab [4];
        logic [15:0] tm_tab [4];
        th_tab = '{16'd2047, 16'd2048, 16'hFFFF, 16'd0};
        tm_tab = '{16'd255, 16'd256, 16'hFFFF, 16'd0};
        for (int i = 0; i < 4; i++) begin
            set_preset(4'(6 + i), th_tab[i], tm_tab[i]);
            run_seq(4'(6 + i), th_tab[i], tm_tab[i], -1, 4'h0, 16'd0, 16'd0, 1'b1, -1);
        end
    endtask

    task automatic test_random();
        logic [3:0]  e;
        logic [15:0] th;
        logic [15:0] tm;
        for (int i = 0; i < 6; i++) begin
            e  = 4'((int'(applied_enum) + $urandom_range(1, 15)) % 16);
            th = 16'($urandom_range(0, 4095));
            tm = 16'($urandom);
            set_preset(e, th, tm);
            run_seq(e, th, tm, -1, 4'h0, 16'd0, 16'd0, 1'b1, -1);
        end
    endtask

    task automatic test_midchange();
        logic [3:0] e1;
        logic [3:0] e2;
        e1 = applied_enum + 4'd1;
        e2 = applied_enum + 4'd4;
        set_preset(e1, 16'd150, 16'd10);
        run_seq(e1, 16'd150, 16'd10, 4, e2, 16'd3000, 16'd700, 1'b1, -1);
        run_seq(e2, 16'd3000, 16'd700, -1, 4'h0, 16'd0, 16'd0, 1'b1, -1);
    endtask

    task automatic test_enable_drop();
        logic [3:0] e;
        e = applied_enum + 4'd7;
        set_preset(e, 16'd1234, 16'd321);
        run_seq(e, 16'd1234, 16'd321, 2, e, 16'd1234, 16'd321, 1'b0, -1);
        enable = 1'b1;
        expect_quiet(20, "no_retrigger_same_preset");
    endtask

    task automatic test_mid_reset();
        logic [3:0] e;
        e = applied_enum + 4'd3;
        set_preset(e, 16'd500, 16'd40);
        run_seq(e, 16'd500, 16'd40, -1, 4'h0, 16'd0, 16'd0, 1'b1, 5);
        @(negedge clk);
        checks++;
        if (cfg_enum !== 4'h0 || cfg_busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_mid_seq got enum=%h busy=%b want 0/0", cfg_enum, cfg_busy);
        end
        rst_n = 1'b1;
        run_seq(e, 16'd500, 16'd40, -1, 4'h0, 16'd0, 16'd0, 1'b1, -1);
    endtask

`ifdef THRESH_CFG_ACK_TIMEOUT_EN
    task automatic test_timeout();
        logic [3:0] e;
        int n;
        int dones;
        e = applied_enum + 4'd2;
        set_preset(e, 16'd77, 16'd88);
        @(negedge clk);
        checks++;
        if (wr_req !== 1'b1) begin
            errors++;
            $display("[TB] FAIL timeout_start got req=%b want 1", wr_req);
        end
        n = 0;
        dones = 0;
        do begin
            @(negedge clk);
            n++;
            if (cfg_done === 1'b1) dones++;
        end while (cfg_error !== 1'b1 && n < 200);
        checks++;
        if (n !== 20 || dones !== 0) begin
            errors++;
            $display("[TB] FAIL timeout_latency got %0d cycles done=%0d want 20 cycles done=0", n, dones);
        end
        checks++;
        if (cfg_busy !== 1'b0 || wr_req !== 1'b0) begin
            errors++;
            $display("[TB] FAIL timeout_abort got busy=%b req=%b want 0/0", cfg_busy, wr_req);
        end
        @(negedge clk);
        checks++;
        if (cfg_error !== 1'b0 || wr_req !== 1'b1) begin
            errors++;
            $display("[TB] FAIL timeout_retry got err=%b req=%b want 0/1", cfg_error, wr_req);
        end
        run_seq(e, 16'd77, 16'd88, -1, 4'h0, 16'd0, 16'd0, 1'b1, -1);
    endtask
`endif

    initial begin
        test_reset();
        test_enable_gate();
        test_saturation();
        test_boundaries();
        test_random();
        test_midchange();
        test_enable_drop();
        test_mid_reset();
`ifdef THRESH_CFG_ACK_TIMEOUT_EN
        test_timeout();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/thresh_preset_cfg_sequencer.md
Name: thresh_preset_cfg_sequencer

Overview:
- Applies the active threshold/timer preset to the ADXL362 accelerometer.
- Watches the preset selector outputs (enum, threshold, timer). On a new preset, it issues a fixed sequence of nine register writes to the SPI command driver over a req/ack handshake: standby, activity/inactivity thresholds and timers, then measure.
- Sits between the preset selector and the SPI/ACL driver in the 20 MHz domain.

Parameters:
- parm_power_ctl_measure, 8'h02, POWER_CTL value written as the final step (measurement mode).
- parm_power_ctl_standby, 8'h00, POWER_CTL value written as the first step.
- parm_ack_timeout, 16'd50000, cycles to wait for i_wr_ack before abort. Used only with the optional feature.

Ports:
- i_clk_20mhz  in  1  system clock, 20 MHz.
- i_rstn_20mhz  in  1  asynchronous, active-low reset.
- i_enable  in  1  high once the ACL driver has finished init; gates new sequences.
- i_preset_enum  in  4  preset index from the selector.
- i_preset_thresh  in  16  preset threshold from the selector.
- i_preset_timer  in  16  preset timer from the selector.
- o_wr_req  out  1  register write request.
- o_wr_addr  out  8  ADXL362 register address.
- o_wr_data  out  8  register data.
- i_wr_ack  in  1  one-cycle pulse: current write complete.
- o_cfg_busy  out  1  sequence in progress.
- o_cfg_done  out  1  one-cycle pulse: sequence completed.
- o_cfg_enum  out  4  enum of the last successfully applied preset.
- o_cfg_error  out  1  one-cycle pulse: ack timeout. Tied 0 when the feature is compiled out.

Behaviour:
- Clock and reset: one clock, i_clk_20mhz; reset i_rstn_20mhz is asynchronous and active-low.
- All outputs are registered.
- Reset values: o_wr_req=0, o_wr_addr=8'h00, o_wr_data=8'h00, o_cfg_busy=0, o_cfg_done=0, o_cfg_enum=4'h0, o_cfg_error=0, applied-valid flag=0, state=ST_IDLE.
- Trigger condition, evaluated in ST_IDLE: i_enable && (!applied_valid || i_preset_enum != o_cfg_enum).
- ST_IDLE, on trigger:
  - Latch enum, thresh, timer; step:=0; go to ST_WAIT.
  - o_wr_req, o_cfg_busy and the step-0 addr/data are all visible the cycle after the trigger cycle.
- ST_WAIT:
  - Hold o_wr_req=1 with addr/data stable until i_wr_ack=1.
  - On ack with step<8: step++, go to ST_GAP.
  - On ack with step==8: go to ST_DONE.
  - An i_wr_ack seen while o_wr_req=0 is ignored.
- ST_GAP: o_wr_req=0 for exactly one cycle; drive the next step's addr/data; go to ST_WAIT.
- ST_DONE, one cycle:
  - o_cfg_done=1; o_cfg_enum:=latched enum; applied_valid:=1; o_cfg_busy:=0; go to ST_IDLE.
- Step table (addr, data):
  - 0: 0x2D, parm_power_ctl_standby
  - 1: 0x20, thr_sat[7:0]
  - 2: 0x21, {5'b0, thr_sat[10:8]}
  - 3: 0x22, tact_sat
  - 4: 0x23, thr_sat[7:0]
  - 5: 0x24, {5'b0, thr_sat[10:8]}
  - 6: 0x25, timer[7:0]
  - 7: 0x26, timer[15:8]
  - 8: 0x2D, parm_power_ctl_measure
- Width and saturation rules:
  - thr_sat is 11 bits: latched thresh > 2047 gives 2047, else thresh[10:0].
  - tact_sat is 8 bits: latched timer > 255 gives 255, else timer[7:0].
  - Inactivity time uses the full 16-bit timer.
- Preset change mid-sequence: the latched values are used to completion. The mismatch retriggers from ST_IDLE the cycle after ST_DONE.
- i_enable dropping mid-sequence: the sequence still completes, so the device is never left in standby.
- Reset mid-sequence: o_wr_req drops asynchronously and applied_valid clears, so the preset is reapplied after reset once i_enable is high.
- Minimum sequence length: 1 trigger cycle, then 9 writes with 8 one-cycle gaps, then 1 done cycle.

Optional Feature:
- Macro: THRESH_CFG_ACK_TIMEOUT_EN.
- When defined:
  - A 16-bit counter clears on entry to ST_WAIT and increments each ST_WAIT cycle.
  - If it reaches parm_ack_timeout without an ack: o_wr_req:=0, o_cfg_error pulses for 1 cycle, o_cfg_busy:=0, return to ST_IDLE.
  - o_cfg_enum and applied_valid are unchanged, so the trigger refires on the next cycle if still enabled.
- When undefined: no counter; ST_WAIT waits indefinitely; o_cfg_error is constant 0.

Decomposition:
- Package acl_cfg_pkg holds:
  - state typedef t_cfgseq_state {ST_IDLE, ST_WAIT, ST_GAP, ST_DONE};
  - register address constants (ADDR_THRESH_ACT_L ... ADDR_POWER_CTL);
  - c_cfg_last_step=4'd8;
  - c_thresh_max=11'd2047.
- One sub-module is natural: cfg_step_rom, a combinational step index plus latched values producing addr/data, holding the table and saturation logic.
- FSM, handshake and timeout stay in the top level.

Test Plan:
- Reset released, i_enable=1, enum=0, thresh=150, timer=10, ack 3 cycles after each req:
  - Writes are (2D,00) (20,96) (21,00) (22,0A) (23,96) (24,00) (25,0A) (26,00) (2D,02).
  - Then o_cfg_done for 1 cycle and o_cfg_enum=0.
- thresh=3000, timer=700:
  - Reg 0x20=0xFF, 0x21=0x07, 0x22=0xFF, 0x25=0xBC, 0x26=0x02.
- Enum changes 0 to 3 during step 4:
  - The first sequence finishes with enum-0 values and o_cfg_enum=0.
  - A new sequence starts the cycle after done; it finishes with o_cfg_enum=3.
- i_enable=0 at reset release: no o_wr_req for 100 cycles. Raise i_enable: req rises the following cycle.
- Assert i_rstn_20mhz=0 during step 5:
  - o_wr_req=0 immediately.
  - After release with i_enable=1, a full 9-write sequence restarts at step 0.
- With THRESH_CFG_ACK_TIMEOUT_EN and parm_ack_timeout=20, withhold ack:
  - o_cfg_error pulses once 20 cycles after req rises.
  - o_cfg_busy=0; a retry starts next cycle; o_cfg_done never pulses.
